mc16_mem_arbiter: RTL and testbench

Shares the single 8-bit external memory port of tt_um_barilwil_microcore16 between two requesters: instruction fetch (IF) and data load/store (D). Each 16-bit word access is sequenced as two byte beats on the external bus, low byte first. Arbitration is round-robin. A per-beat watchdog aborts stalled accesses. The block sits between the core's fetch/LSU logic and the uio-pin memory bus driver.

---
 rtl/mc16_mem_arbiter.sv | 213 +++++++++++++++++++++
 tb/tb_mc16_mem_arbiter.sv | 297 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mc16_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mc16_mem_arbiter
// Purpose  : Round-robin arbiter between instruction fetch and data load/store
//            for an 8-bit external memory port. Each 16-bit word is moved as
//            two byte beats, low byte first. A per-beat watchdog aborts a beat
//            that is never acknowledged.
// Revision : 1.0 - initial release
// ============================================================================
module mc16_mem_arbiter #(
    parameter int ADDR_W  = 8,
    parameter int TIMEOUT = 15
) (
    input  logic              clk,
    input  logic              rst_n,
    // instruction fetch requester
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic              if_done,
    output logic [15:0]       if_rdata,
    // data requester
    input  logic              d_req,
    input  logic              d_we,
    input  logic [ADDR_W-1:0] d_addr,
    input  logic [15:0]       d_wdata,
    output logic              d_done,
    output logic [15:0]       d_rdata,
    // completion status
    output logic              err,
    // external byte bus
    output logic              ext_req,
    output logic              ext_we,
    output logic [ADDR_W:0]   ext_addr,
    output logic [7:0]        ext_wdata,
    input  logic [7:0]        ext_rdata,
    input  logic              ext_ack,
    output logic              owner
);

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        LO   = 2'd1,
        HI   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Watchdog fires on the last allowed wait cycle of a beat; an ack on that
    // same cycle still wins because the ack branch is tested first.
    localparam bit         WDOG_EN   = (TIMEOUT != 0);
    localparam logic [7:0] WDOG_LAST = (TIMEOUT == 0) ? 8'd0 : 8'(TIMEOUT - 1);

    state_t              state, state_nx;
    logic                last_d, last_d_nx;      // 1 = D was granted last
    logic                lat_we, lat_we_nx;
    logic [ADDR_W-1:0]   lat_addr, lat_addr_nx;
    logic [15:0]         lat_wdata, lat_wdata_nx;
    logic [7:0]          lo_byte, lo_byte_nx;
    logic [7:0]          wdog, wdog_nx;

    logic                if_done_nx, d_done_nx, err_nx;
    logic [15:0]         if_rdata_nx, d_rdata_nx;
    logic                ext_req_nx, ext_we_nx;
    logic [ADDR_W:0]     ext_addr_nx;
    logic [7:0]          ext_wdata_nx;
    logic                owner_nx;

    logic                grant_d;
    logic                wd_expire;
    logic                fin, fin_to;
    logic [15:0]         fin_data;

    // D wins only if IF is absent or IF was the last one served.
    assign grant_d   = d_req && (!if_req || !last_d);
    assign wd_expire = WDOG_EN && (wdog == WDOG_LAST);

    // Next-state and next-output computation; every output is registered.
    always_comb begin
        state_nx     = state;
        last_d_nx    = last_d;
        lat_we_nx    = lat_we;
        lat_addr_nx  = lat_addr;
        lat_wdata_nx = lat_wdata;
        lo_byte_nx   = lo_byte;
        wdog_nx      = 8'd0;
        if_done_nx   = 1'b0;
        d_done_nx    = 1'b0;
        err_nx       = 1'b0;
        if_rdata_nx  = if_rdata;
        d_rdata_nx   = d_rdata;
        ext_req_nx   = 1'b0;
        ext_we_nx    = 1'b0;
        ext_addr_nx  = '0;
        ext_wdata_nx = 8'd0;
        owner_nx     = owner;
        fin          = 1'b0;
        fin_to       = 1'b0;
        fin_data     = 16'd0;

        case (state)
            IDLE: begin
                if (if_req || d_req) begin
                    owner_nx     = grant_d;
                    lat_addr_nx  = grant_d ? d_addr : if_addr;
                    lat_we_nx    = grant_d && d_we;
                    lat_wdata_nx = grant_d ? d_wdata : 16'd0;
                    state_nx     = LO;
                    ext_req_nx   = 1'b1;
                    ext_we_nx    = grant_d && d_we;
                    ext_addr_nx  = {(grant_d ? d_addr : if_addr), 1'b0};
                    ext_wdata_nx = grant_d ? d_wdata[7:0] : 8'd0;
                end
            end
            LO: begin
                if (ext_ack) begin
                    lo_byte_nx   = ext_rdata;
                    state_nx     = HI;
                    ext_req_nx   = 1'b1;
                    ext_we_nx    = lat_we;
                    ext_addr_nx  = {lat_addr, 1'b1};
                    ext_wdata_nx = lat_wdata[15:8];
                end else if (wd_expire) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end else begin
                    wdog_nx      = wdog + 8'd1;
                    ext_req_nx   = 1'b1;
                    ext_we_nx    = ext_we;
                    ext_addr_nx  = ext_addr;
                    ext_wdata_nx = ext_wdata;
                end
            end
            HI: begin
                if (ext_ack) begin
                    fin      = 1'b1;
                    fin_data = {ext_rdata, lo_byte};
                end else if (wd_expire) begin
                    fin    = 1'b1;
                    fin_to = 1'b1;
                end else begin
                    wdog_nx      = wdog + 8'd1;
                    ext_req_nx   = 1'b1;
                    ext_we_nx    = ext_we;
                    ext_addr_nx  = ext_addr;
                    ext_wdata_nx = ext_wdata;
                end
            end
            DONE: begin
                last_d_nx = owner;
                state_nx  = IDLE;
            end
            default: state_nx = IDLE;
        endcase

        // Completion: a timed-out access returns all ones with err set.
        if (fin) begin
            state_nx = DONE;
            err_nx   = fin_to;
            if (fin_to) begin
                fin_data = 16'hFFFF;
            end
            if (owner) begin
                d_done_nx  = 1'b1;
                d_rdata_nx = fin_data;
            end else begin
                if_done_nx  = 1'b1;
                if_rdata_nx = fin_data;
            end
        end
    end

    // State and output registers with asynchronous clear.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            last_d    <= 1'b1;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= 16'd0;
            lo_byte   <= 8'd0;
            wdog      <= 8'd0;
            if_done   <= 1'b0;
            d_done    <= 1'b0;
            err       <= 1'b0;
            if_rdata  <= 16'd0;
            d_rdata   <= 16'd0;
            ext_req   <= 1'b0;
            ext_we    <= 1'b0;
            ext_addr  <= '0;
            ext_wdata <= 8'd0;
            owner     <= 1'b0;
        end else begin
            state     <= state_nx;
            last_d    <= last_d_nx;
            lat_we    <= lat_we_nx;
            lat_addr  <= lat_addr_nx;
            lat_wdata <= lat_wdata_nx;
            lo_byte   <= lo_byte_nx;
            wdog      <= wdog_nx;
            if_done   <= if_done_nx;
            d_done    <= d_done_nx;
            err       <= err_nx;
            if_rdata  <= if_rdata_nx;
            d_rdata   <= d_rdata_nx;
            ext_req   <= ext_req_nx;
            ext_we    <= ext_we_nx;
            ext_addr  <= ext_addr_nx;
            ext_wdata <= ext_wdata_nx;
            owner     <= owner_nx;
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_mc16_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : tb_mc16_mem_arbiter
// Purpose  : Self-checking bench for mc16_mem_arbiter with a byte memory
//            model and a completion scoreboard.
// Revision : 1.0 - initial release
// ============================================================================
module tb_mc16_mem_arbiter;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        if_req = 1'b0;
    logic [7:0]  if_addr = 8'd0;
    logic        if_done;
    logic [15:0] if_rdata;
    logic        d_req = 1'b0;
    logic        d_we = 1'b0;
    logic [7:0]  d_addr = 8'd0;
    logic [15:0] d_wdata = 16'd0;
    logic        d_done;
    logic [15:0] d_rdata;
    logic        err;
    logic        ext_req;
    logic        ext_we;
    logic [8:0]  ext_addr;
    logic [7:0]  ext_wdata;
    logic [7:0]  ext_rdata = 8'd0;
    logic        ext_ack = 1'b0;
    logic        owner;

    mc16_mem_arbiter #(.ADDR_W(8), .TIMEOUT(15)) dut (
        .clk(clk), .rst_n(rst_n),
        .if_req(if_req), .if_addr(if_addr), .if_done(if_done), .if_rdata(if_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_done(d_done), .d_rdata(d_rdata), .err(err),
        .ext_req(ext_req), .ext_we(ext_we), .ext_addr(ext_addr),
        .ext_wdata(ext_wdata), .ext_rdata(ext_rdata), .ext_ack(ext_ack),
        .owner(owner)
    );

    always #5 clk = ~clk;

    int n_chk  = 0;
    int n_pass = 0;

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    endtask

    // ---------------- memory model ----------------
    logic [7:0] mem [0:511];
    int  wait_n = 0;
    bit  no_ack = 1'b0;
    int  wcnt   = 0;

    // Acknowledge a beat after wait_n idle cycles; writes update the array.
    always @(negedge clk) begin
        if (!ext_req || no_ack || !rst_n) begin
            ext_ack = 1'b0;
            wcnt    = 0;
        end else if (wcnt >= wait_n) begin
            ext_ack   = 1'b1;
            ext_rdata = mem[ext_addr];
            if (ext_we) mem[ext_addr] = ext_wdata;
            wcnt = 0;
        end else begin
            ext_ack = 1'b0;
            wcnt++;
        end
    end

    function automatic logic [15:0] word_at(input logic [7:0] a);
        return {mem[{a, 1'b1}], mem[{a, 1'b0}]};
    endfunction

    // ---------------- scoreboard ----------------
    typedef struct {
        logic        is_d;
        logic        err;
        logic        chk_data;
        logic [15:0] data;
    } exp_t;
    exp_t sb[$];

    int n_if = 0;
    int n_d  = 0;
    bit prev_done = 1'b0;

    task automatic push(input logic is_d, input logic e, input logic cd, input logic [15:0] dat);
        exp_t x;
        x.is_d = is_d; x.err = e; x.chk_data = cd; x.data = dat;
        sb.push_back(x);
    endtask

    // Compare every completion pulse against the oldest expected entry.
    always @(negedge clk) begin
        exp_t x;
        if (rst_n && (if_done || d_done)) begin
            chk("done_single", {31'd0, prev_done}, 32'd0);
            chk("done_excl", {31'd0, if_done && d_done}, 32'd0);
            chk("sb_avail", {31'd0, sb.size() != 0}, 32'd1);
            if (sb.size() != 0) begin
                x = sb.pop_front();
                chk("done_who", {31'd0, d_done}, {31'd0, x.is_d});
                chk("owner", {31'd0, owner}, {31'd0, x.is_d});
                chk("err", {31'd0, err}, {31'd0, x.err});
                if (x.chk_data)
                    chk("rdata", {16'd0, (d_done ? d_rdata : if_rdata)}, {16'd0, x.data});
            end
            if (if_done) n_if++;
            if (d_done)  n_d++;
        end
        prev_done = rst_n && (if_done || d_done);
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        step();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    task automatic wait_done(input int max_cyc);
        int took;
        took = 0;
        do begin
            @(negedge clk);
            took++;
        end while (!(if_done || d_done) && took < max_cyc);
        chk("done_seen", {31'd0, if_done || d_done}, 32'd1);
    endtask

    int n_hi;

    initial begin
        for (int i = 0; i < 512; i++) mem[i] = 8'(i * 37 + 11);
        mem[9'h024] = 8'h34;
        mem[9'h025] = 8'h56;

        // ---- reset state ----
        do_reset();
        @(negedge clk);
        chk("rst_ext_req", {31'd0, ext_req}, 32'd0);
        chk("rst_owner", {31'd0, owner}, 32'd0);
        chk("rst_done", {30'd0, if_done, d_done}, 32'd0);
        chk("rst_rdata", {if_rdata, d_rdata}, 32'd0);
        chk("rst_ext_addr", {23'd0, ext_addr}, 32'd0);

        // ---- fetch, zero wait ----
        step();
        if_addr = 8'h12; if_req = 1'b1;
        push(1'b0, 1'b0, 1'b1, 16'h5634);
        @(negedge clk);
        for (int k = 1; k <= 3; k++) begin
            step();
            @(negedge clk);
            if (k == 1) begin
                chk("t1_req", {31'd0, ext_req}, 32'd1);
                chk("t1_lo_addr", {23'd0, ext_addr}, 32'h024);
                chk("t1_we", {31'd0, ext_we}, 32'd0);
            end
            if (k == 2) chk("t1_hi_addr", {23'd0, ext_addr}, 32'h025);
            if (k == 3) begin
                chk("t1_done_c3", {31'd0, if_done}, 32'd1);
                chk("t1_req_off", {31'd0, ext_req}, 32'd0);
            end
        end
        step();
        if_req = 1'b0;

        // ---- data write, two wait cycles per beat, fields change mid-access ----
        wait_n = 2;
        step();
        d_req = 1'b1; d_we = 1'b1; d_addr = 8'h80; d_wdata = 16'hBEEF;
        push(1'b1, 1'b0, 1'b0, 16'h0000);
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 2) begin
                d_addr = 8'h00; d_wdata = 16'h0000; d_we = 1'b0;
            end
            @(negedge clk);
            if (k == 1) begin
                chk("t2_lo_addr", {23'd0, ext_addr}, 32'h100);
                chk("t2_lo_wdata", {24'd0, ext_wdata}, 32'hEF);
                chk("t2_we", {31'd0, ext_we}, 32'd1);
            end
            if (k == 4) begin
                chk("t2_hi_addr", {23'd0, ext_addr}, 32'h101);
                chk("t2_hi_wdata", {24'd0, ext_wdata}, 32'hBE);
                chk("t2_hi_we", {31'd0, ext_we}, 32'd1);
            end
            if (k == 6) chk("t2_not_yet", {31'd0, d_done}, 32'd0);
            if (k == 7) chk("t2_done_c7", {31'd0, d_done}, 32'd1);
        end
        step();
        d_req = 1'b0; d_we = 1'b0;
        wait_n = 0;
        chk("t2_mem", {16'd0, mem[9'h101], mem[9'h100]}, 32'hBEEF);

        // ---- back-to-back fetch, 4-cycle period ----
        step();
        if_addr = 8'h10; if_req = 1'b1;
        push(1'b0, 1'b0, 1'b1, word_at(8'h10));
        push(1'b0, 1'b0, 1'b1, word_at(8'h11));
        @(negedge clk);
        for (int k = 1; k <= 7; k++) begin
            step();
            if (k == 4) if_addr = 8'h11;
            @(negedge clk);
            chk("t6_done_timing", {31'd0, if_done}, {31'd0, (k == 3 || k == 7)});
            if (k == 5) chk("t6_addr", {23'd0, ext_addr}, 32'h022);
        end
        step();
        if_req = 1'b0;

        // ---- both requesters held: round-robin order after reset ----
        do_reset();
        n_if = 0; n_d = 0;
        if_addr = 8'h20; d_addr = 8'h30; d_we = 1'b0;
        push(1'b0, 1'b0, 1'b1, word_at(8'h20));
        push(1'b1, 1'b0, 1'b1, word_at(8'h30));
        push(1'b0, 1'b0, 1'b1, word_at(8'h20));
        push(1'b1, 1'b0, 1'b1, word_at(8'h30));
        if_req = 1'b1; d_req = 1'b1;
        for (int k = 0; k < 60; k++) begin
            @(negedge clk);
            #1;
            if (n_if + n_d >= 4) break;
            @(posedge clk);
            #1;
            if_req = (n_if < 2);
            d_req  = (n_d < 2);
        end
        chk("t3_count", 32'(n_if + n_d), 32'd4);
        step();
        if_req = 1'b0; d_req = 1'b0;
        repeat (3) @(negedge clk);
        chk("t3_no_extra", {31'd0, ext_req}, 32'd0);

        // ---- watchdog: ack never arrives ----
        no_ack = 1'b1;
        step();
        d_addr = 8'h40; d_we = 1'b0; d_req = 1'b1;
        push(1'b1, 1'b1, 1'b1, 16'hFFFF);
        n_hi = 0;
        for (int k = 0; k < 40; k++) begin
            @(negedge clk);
            if (d_done) break;
            n_hi += {31'd0, ext_req};
        end
        chk("t4_done", {31'd0, d_done}, 32'd1);
        chk("t4_req_len", 32'(n_hi), 32'd15);
        chk("t4_req_off", {31'd0, ext_req}, 32'd0);
        step();
        d_req = 1'b0;
        no_ack = 1'b0;

        // ---- asynchronous reset during the high beat ----
        step();
        if_addr = 8'h05; if_req = 1'b1;
        @(negedge clk);
        @(negedge clk);
        @(negedge clk);
        chk("t5_in_hi", {23'd0, ext_addr}, 32'h00B);
        #2 rst_n = 1'b0;
        #1;
        chk("t5_req_clr", {31'd0, ext_req}, 32'd0);
        chk("t5_owner_clr", {31'd0, owner}, 32'd0);
        chk("t5_done_clr", {30'd0, if_done, d_done}, 32'd0);
        chk("t5_rdata_clr", {if_rdata, d_rdata}, 32'd0);
        @(posedge clk);
        #1 rst_n = 1'b1;
        push(1'b0, 1'b0, 1'b1, word_at(8'h05));
        @(negedge clk);
        @(negedge clk);
        chk("t5_fresh_req", {31'd0, ext_req}, 32'd1);
        chk("t5_fresh_lo", {23'd0, ext_addr}, 32'h00A);
        wait_done(20);
        step();
        if_req = 1'b0;

        repeat (3) @(negedge clk);
        chk("sb_drained", 32'(sb.size()), 32'd0);
        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
